// File: rtl/uart_param_transceiver.sv
// Parameterised UART transmitter and receiver sharing one clock.
// TX and RX are fully independent; only the clock and reset are common.
module uart_param_transceiver #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CPB / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rxState_t;

  function automatic logic parityOf(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  txState_t             txState_q, txState_d;
  logic [CNT_W-1:0]     txCnt_q, txCnt_d;
  logic [3:0]           txBit_q, txBit_d;
  logic [DATA_BITS-1:0] txShift_q, txShift_d;
  logic                 txPar_q, txPar_d;
  logic                 txBitEnd, txLastStop, txAccept, txLine;

  assign txBitEnd   = (txCnt_q == CNT_LAST);
  assign txLastStop = (txState_q == TX_STOP) && txBitEnd && (txBit_q == STOP_LAST) && !rst;
  // A request during the final stop-bit cycle is taken so frames can abut.
  assign txAccept   = tx_start && !rst && ((txState_q == TX_IDLE) || txLastStop);

  assign tx_done = txLastStop;
  assign tx_busy = (txState_q != TX_IDLE) && !txLastStop && !rst;
  assign tx      = rst | txLine;

  always_comb begin
    txLine = 1'b1;
    case (txState_q)
      TX_START:  txLine = 1'b0;
      TX_DATA:   txLine = txShift_q[0];
      TX_PARITY: txLine = txPar_q;
      default:   txLine = 1'b1;
    endcase
  end

  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txBitEnd ? '0 : txCnt_q + 1'b1;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPar_d   = txPar_q;
    case (txState_q)
      TX_IDLE: begin
        txCnt_d = '0;
        if (txAccept) begin
          txState_d = TX_START;
          txShift_d = tx_data;
          txPar_d   = parityOf(tx_data);
        end
      end
      TX_START: begin
        if (txBitEnd) begin
          txState_d = TX_DATA;
          txBit_d   = '0;
        end
      end
      TX_DATA: begin
        if (txBitEnd) begin
          txShift_d = {1'b0, txShift_q[DATA_BITS-1:1]};
          if (txBit_q == DATA_LAST) begin
            txState_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
            txBit_d   = '0;
          end else begin
            txBit_d = txBit_q + 4'd1;
          end
        end
      end
      TX_PARITY: begin
        if (txBitEnd) begin
          txState_d = TX_STOP;
          txBit_d   = '0;
        end
      end
      TX_STOP: begin
        if (txBitEnd) begin
          if (txBit_q != STOP_LAST) begin
            txBit_d = txBit_q + 4'd1;
          end else if (txAccept) begin
            txState_d = TX_START;
            txShift_d = tx_data;
            txPar_d   = parityOf(tx_data);
          end else begin
            txState_d = TX_IDLE;
          end
        end
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      txPar_q   <= txPar_d;
    end
  end

  rxState_t             rxState_q, rxState_d;
  logic [CNT_W-1:0]     rxCnt_q, rxCnt_d;
  logic [3:0]           rxBit_q, rxBit_d;
  logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
  logic                 rxParBit_q, rxParBit_d;
  logic [DATA_BITS-1:0] rxData_q, rxData_d;
  logic                 rxValid_q, rxValid_d;
  logic                 rxPerr_q, rxPerr_d;
  logic                 rxFerr_q, rxFerr_d;
  logic                 rxSync1_q, rxSync2_q, rxPrev_q;
  logic                 rxFall, rxBitEnd;

  assign rxFall   = rxPrev_q & ~rxSync2_q;
  assign rxBitEnd = (rxCnt_q == CNT_LAST);

  assign rx_data       = rxData_q;
  assign rx_valid      = rxValid_q;
  assign rx_parity_err = rxPerr_q;
  assign rx_frame_err  = rxFerr_q;

  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxBitEnd ? '0 : rxCnt_q + 1'b1;
    rxBit_d    = rxBit_q;
    rxShift_d  = rxShift_q;
    rxParBit_d = rxParBit_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    rxPerr_d   = 1'b0;
    rxFerr_d   = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        rxCnt_d = '0;
        if (rxFall) rxState_d = RX_START;
      end
      // Half a bit after the edge: a line already back high was a glitch.
      RX_START: begin
        if (rxCnt_q == CNT_HALF) begin
          rxCnt_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxSync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rxBitEnd) begin
          rxShift_d = {rxSync2_q, rxShift_q[DATA_BITS-1:1]};
          if (rxBit_q == DATA_LAST) begin
            rxState_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rxBit_d = rxBit_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rxBitEnd) begin
          rxParBit_d = rxSync2_q;
          rxState_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rxBitEnd) begin
          rxData_d  = rxShift_q;
          rxValid_d = 1'b1;
          rxPerr_d  = (PARITY != 0) && (rxParBit_q != parityOf(rxShift_q));
          rxFerr_d  = ~rxSync2_q;
          rxState_d = rxSync2_q ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        rxCnt_d = '0;
        if (rxSync2_q) rxState_d = RX_IDLE;
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1_q  <= 1'b1;
      rxSync2_q  <= 1'b1;
      rxPrev_q   <= 1'b1;
      rxState_q  <= RX_IDLE;
      rxCnt_q    <= '0;
      rxBit_q    <= '0;
      rxShift_q  <= '0;
      rxParBit_q <= 1'b0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      rxPerr_q   <= 1'b0;
      rxFerr_q   <= 1'b0;
    end else begin
      rxSync1_q  <= rx;
      rxSync2_q  <= rxSync1_q;
      rxPrev_q   <= rxSync2_q;
      rxState_q  <= rxState_d;
      rxCnt_q    <= rxCnt_d;
      rxBit_q    <= rxBit_d;
      rxShift_q  <= rxShift_d;
      rxParBit_q <= rxParBit_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      rxPerr_q   <= rxPerr_d;
      rxFerr_q   <= rxFerr_d;
    end
  end

endmodule

// File: tb/tb_uart_param_transceiver.sv
// Bench for uart_param_transceiver: three instances (8N1, 8E1 looped back, 8O1)
// with expected receptions queued by the stimulus and scored by per-lane monitors.
module tb_uart_param_transceiver;

  localparam int CF  = 1_600_000;
  localparam int BR  = 100_000;
  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rxExp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN = 1'b1, rstE = 1'b1, rstO = 1'b1;
  logic txStartN = 1'b0, txStartE = 1'b0, txStartO = 1'b0;
  logic [7:0] txDataN = '0, txDataE = '0, txDataO = '0;
  logic rxN = 1'b1, rxO = 1'b1;
  logic txN, txBusyN, txDoneN, rxValidN, rxPerrN, rxFerrN;
  logic txE, txBusyE, txDoneE, rxValidE, rxPerrE, rxFerrE;
  logic txO, txBusyO, txDoneO, rxValidO, rxPerrO, rxFerrO;
  logic [7:0] rxDataN, rxDataE, rxDataO;

  uart_param_transceiver #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutN (
    .clk(clk), .rst(rstN), .tx_start(txStartN), .tx_data(txDataN), .tx(txN),
    .tx_busy(txBusyN), .tx_done(txDoneN), .rx(rxN), .rx_data(rxDataN),
    .rx_valid(rxValidN), .rx_parity_err(rxPerrN), .rx_frame_err(rxFerrN));

  uart_param_transceiver #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutE (
    .clk(clk), .rst(rstE), .tx_start(txStartE), .tx_data(txDataE), .tx(txE),
    .tx_busy(txBusyE), .tx_done(txDoneE), .rx(txE), .rx_data(rxDataE),
    .rx_valid(rxValidE), .rx_parity_err(rxPerrE), .rx_frame_err(rxFerrE));

  uart_param_transceiver #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutO (
    .clk(clk), .rst(rstO), .tx_start(txStartO), .tx_data(txDataO), .tx(txO),
    .tx_busy(txBusyO), .tx_done(txDoneO), .rx(rxO), .rx_data(rxDataO),
    .rx_valid(rxValidO), .rx_parity_err(rxPerrO), .rx_frame_err(rxFerrO));

  int errors = 0;
  int checks = 0;
  rxExp_t qN[$], qE[$], qO[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic scoreRx(input string lane, input logic valid, input logic [7:0] data,
                         input logic perr, input logic ferr, input bit have, input rxExp_t e);
    if (!valid) begin
      checkOutput({lane, " flags without rx_valid"}, {30'd0, perr, ferr}, 32'd0);
    end else if (!have) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected rx_valid: got data 0x%0h, want no reception", lane, data);
    end else begin
      checkOutput({lane, " rx_data"}, {24'd0, data}, {24'd0, e.data});
      checkOutput({lane, " rx_parity_err"}, {31'd0, perr}, {31'd0, e.perr});
      checkOutput({lane, " rx_frame_err"}, {31'd0, ferr}, {31'd0, e.ferr});
    end
  endtask

  // Per-lane monitors: pop one expectation for every rx_valid pulse.
  always @(negedge clk) begin
    rxExp_t e;
    bit have;
    e = '0;
    have = (qN.size() > 0);
    if (!rstN) begin
      if (rxValidN && have) e = qN.pop_front();
      scoreRx("N", rxValidN, rxDataN, rxPerrN, rxFerrN, have, e);
    end
  end

  always @(negedge clk) begin
    rxExp_t e;
    bit have;
    e = '0;
    have = (qE.size() > 0);
    if (!rstE) begin
      if (rxValidE && have) e = qE.pop_front();
      scoreRx("E", rxValidE, rxDataE, rxPerrE, rxFerrE, have, e);
    end
  end

  always @(negedge clk) begin
    rxExp_t e;
    bit have;
    e = '0;
    have = (qO.size() > 0);
    if (!rstO) begin
      if (rxValidO && have) e = qO.pop_front();
      scoreRx("O", rxValidO, rxDataO, rxPerrO, rxFerrO, have, e);
    end
  end

  // Serial frame driver: bit 0 of 'bits' goes out first, each held one bit time.
  task automatic applyStimulus(input int lane, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (lane == 0) rxN = bits[i];
      else           rxO = bits[i];
      repeat (CPB) @(negedge clk);
    end
    if (lane == 0) rxN = 1'b1;
    else           rxO = 1'b1;
  endtask

  initial begin
    logic [9:0] frame;
    logic       expTx;
    bit         gotDone;
    bit         doneSeen;
    bit         txLow;

    repeat (3) @(negedge clk);
    checkOutput("reset tx", {31'd0, txN}, 32'd1);
    checkOutput("reset tx_busy", {31'd0, txBusyN}, 32'd0);
    checkOutput("reset tx_done", {31'd0, txDoneN}, 32'd0);
    checkOutput("reset rx_data", {24'd0, rxDataN}, 32'd0);
    checkOutput("reset rx_valid", {31'd0, rxValidN}, 32'd0);
    checkOutput("reset rx flags", {30'd0, rxPerrN, rxFerrN}, 32'd0);
    checkOutput("reset tx E", {31'd0, txE}, 32'd1);
    rstN = 1'b0;
    rstE = 1'b0;
    rstO = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 transmit of 0xA5: start, LSB-first data, stop; accept cycle is cycle 0.
    frame = {1'b1, 8'hA5, 1'b0};
    txStartN = 1'b1;
    txDataN  = 8'hA5;
    @(negedge clk);
    txStartN = 1'b0;
    for (int c = 1; c <= 165; c++) begin
      expTx = (c <= 160) ? frame[(c - 1) / CPB] : 1'b1;
      checkOutput($sformatf("N tx cycle %0d", c), {31'd0, txN}, {31'd0, expTx});
      checkOutput($sformatf("N tx_done cycle %0d", c), {31'd0, txDoneN}, {31'd0, (c == 160)});
      checkOutput($sformatf("N tx_busy cycle %0d", c), {31'd0, txBusyN}, {31'd0, (c < 160)});
      @(negedge clk);
    end

    // Reset in the middle of data bit 3 aborts the frame.
    txStartN = 1'b1;
    txDataN  = 8'hA5;
    @(negedge clk);
    txStartN = 1'b0;
    repeat (71) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("N abort tx", {31'd0, txN}, 32'd1);
    checkOutput("N abort tx_busy", {31'd0, txBusyN}, 32'd0);
    checkOutput("N abort tx_done", {31'd0, txDoneN}, 32'd0);
    rstN = 1'b0;
    doneSeen = 1'b0;
    txLow = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (txDoneN) doneSeen = 1'b1;
      if (!txN) txLow = 1'b1;
    end
    checkOutput("N no tx_done after abort", {31'd0, doneSeen}, 32'd0);
    checkOutput("N tx idle after abort", {31'd0, txLow}, 32'd0);

    // 8E1 loopback, back-to-back 0x3C then 0xC3 with tx_start held high.
    qE.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    qE.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
    txStartE = 1'b1;
    txDataE  = 8'h3C;
    @(negedge clk);
    txDataE = 8'hC3;
    gotDone = 1'b0;
    for (int i = 0; i < 400 && !gotDone; i++) begin
      @(negedge clk);
      if (txDoneE) gotDone = 1'b1;
    end
    checkOutput("E first tx_done seen", {31'd0, gotDone}, 32'd1);
    checkOutput("E tx high in done cycle", {31'd0, txE}, 32'd1);
    @(negedge clk);
    txStartE = 1'b0;
    checkOutput("E second start bit without gap", {31'd0, txE}, 32'd0);
    checkOutput("E busy on second frame", {31'd0, txBusyE}, 32'd1);
    gotDone = 1'b0;
    for (int i = 0; i < 400 && !gotDone; i++) begin
      @(negedge clk);
      if (txDoneE) gotDone = 1'b1;
    end
    checkOutput("E second tx_done seen", {31'd0, gotDone}, 32'd1);
    repeat (20) @(negedge clk);

    // 8O1: 0x00 with parity 0 is a parity error; 0x01 with parity 0 is clean.
    qO.push_back('{data: 8'h00, perr: 1'b1, ferr: 1'b0});
    applyStimulus(1, 16'h0400, 11);
    repeat (10) @(negedge clk);
    qO.push_back('{data: 8'h01, perr: 1'b0, ferr: 1'b0});
    applyStimulus(1, 16'h0402, 11);
    repeat (20) @(negedge clk);

    // 8N1: 0x55 with the stop bit held low for two bit times, then a clean frame.
    qN.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
    applyStimulus(0, 16'h00AA, 11);
    repeat (40) @(negedge clk);
    qN.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
    applyStimulus(0, 16'h02B4, 10);
    repeat (20) @(negedge clk);

    // 4-cycle glitch must be rejected; the following frame must still land.
    rxN = 1'b0;
    repeat (4) @(negedge clk);
    rxN = 1'b1;
    repeat (40) @(negedge clk);
    qN.push_back('{data: 8'hA3, perr: 1'b0, ferr: 1'b0});
    applyStimulus(0, 16'h0346, 10);
    repeat (30) @(negedge clk);
    checkOutput("N rx_data holds", {24'd0, rxDataN}, 32'h0000_00A3);

    checkOutput("N expectations drained", qN.size(), 32'd0);
    checkOutput("E expectations drained", qE.size(), 32'd0);
    checkOutput("O expectations drained", qO.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
